oram_path_server: RTL and testbench
===================================

# oram_path_server

Synthesizable bucket-storage responder for the ORAM binary tree: it holds every bucket of the tree and serves whole-path accesses issued by the ORAM client. Per access it streams the D buckets on the path to a requested leaf, root first, then absorbs D write-back buckets for the same path. It sits on the untrusted-memory side of the client's fetch / put_back / flush flow and replaces the behavioural tree array with a cycle-accurate server.

## Interface
- D, 6: tree depth in levels; leaves = 2^(D-1), nodes = 2^D-1
- K, 3: tuples per bucket
- A, 8: bytes per block value
- clk  in  1  clock; everything is clocked on the rising edge
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  access request
- req_ready  out  1  server idle, accepts request
- req_leaf  in  D-1  target leaf (pos)
- rd_valid  out  1  rd_bucket valid
- rd_ready  in  1  client accepts rd_bucket
- rd_bucket  out  BUCKET_W  bucket read from the path
- rd_level  out  LW=$clog2(D)  level of rd_bucket, 0 = root
- rd_last  out  1  rd_bucket is the leaf level
- wr_valid  in  1  write-back bucket valid
- wr_ready  out  1  server accepts a write-back bucket
- wr_bucket  in  BUCKET_W  bucket for the next path level
- busy  out  1  state != IDLE
- integrity_err  out  1  sticky path-consistency error (see Configuration)

## Operation
- Tuple layout, MSB→LSB: valid, val_valid, val[8A-1:0], b_number[D-1:0], pos_valid, pos[D-2:0]; TUPLE_W = 8A+2D+2 = 78 for the defaults; BUCKET_W = K*TUPLE_W; tuple k occupies bits [k*TUPLE_W +: TUPLE_W].
- Node index: root = 1; level L = 2*idx(L-1) + pos[L-1], where pos is the latched leaf. Storage address = idx-1.
- States: INIT → IDLE → READ → WRITE → IDLE.
- INIT: writes an all-zero bucket to addresses 0 .. 2^D-2, one per cycle, then moves to IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch req_leaf, clear the level counter, and move to READ.
- READ: present level 0 .. D-1 in order. The level advances only on rd_valid&&rd_ready. After the handshake at level D-1 (rd_last=1), move to WRITE.
- WRITE: wr_ready=1. Each wr_valid&&wr_ready writes wr_bucket to the path node at the write-level counter (root first, 0 .. D-1). After the D-th write, move to IDLE.
- Ignored inputs: req_valid outside IDLE, wr_valid outside WRITE, rd_ready while rd_valid=0.
- Reset mid-operation aborts the access and restarts INIT. Tree contents after reset are all-zero; no access is partially retained.

## Timing
- Reset values: req_ready=0, rd_valid=0, rd_bucket=0, rd_level=0, rd_last=0, wr_ready=0, busy=1, integrity_err=0; state=INIT.
- After rst deasserts, INIT lasts 2^D-1 cycles (63 for the defaults). req_ready rises the following cycle.
- Storage is a flop array with a combinational read and a registered rd_bucket.
  - Request accepted at cycle T → level 0 is presented with rd_valid=1 at T+1.
  - With rd_ready held high, level L is presented at T+1+L.
- Backpressure: while rd_valid&&!rd_ready, rd_bucket, rd_level and rd_last hold stable.
- Write bucket accepted at cycle W is visible to reads from W+1.
- After the final write handshake at W, req_ready=1 at W+1.
- Minimum access: 1 request + D read + D write cycles.

## Configuration
- ORAM_SRV_INTEGRITY_EN defined:
  - Each accepted write-back bucket at level L is checked.
  - Any tuple with valid=1 and pos_valid=1 and pos[L-1:0] != leaf[L-1:0] sets integrity_err the cycle after the handshake.
  - integrity_err clears only on rst. The write still completes.
- Not defined: no checker logic; integrity_err is tied to 0.

## Structure
- oramPkg gains: TUPLE_W and BUCKET_W localparams derived from d, K and a; a packed oram_tuple_t typedef matching the layout above; and the server state enum (INIT, IDLE, READ, WRITE).
- One sub-module, oram_bucket_store: a flop array of 2^D-1 buckets with one combinational read port and one synchronous write port. Its write port is shared by the INIT sweep and WRITE.
- Node-index computation stays in oram_path_server.

## Test plan
- Reset release: req_ready=0 for 63 cycles, then 1. Read of leaf 5'b00000 → 6 all-zero buckets, rd_level 0..5, rd_last only at level 5.
- Write-back on leaf 5'b00101 where level 2 holds tuple {b_number=9, pos=5'b00101, val=64'hDEADBEEF_00000001}:
  - re-read leaf 5'b10101 → the tuple appears at level 2 (node 6);
  - read leaf 5'b00110 → level 2 (node 5) is empty.
- Backpressure: rd_ready low for 3 cycles at level 3 → rd_bucket and rd_level=3 stable, no level skipped or duplicated.
- rst pulse during READ at level 2 → outputs take reset values; INIT sweep runs again; the previously written tuple reads back as zero.
- ORAM_SRV_INTEGRITY_EN: on the leaf 5'b00101 path, a level-2 tuple with pos=5'b00000 → integrity_err=1 from the next cycle and it stays set. Without the macro it stays 0.
- Protocol misuse: req_valid during WRITE and wr_valid during READ have no effect, and no storage write occurs.

Source files
------------

// File: rtl/oram_path_server_pkg.sv
// Shared constants, tuple layout and FSM state type for the ORAM path server.
package oram_path_server_pkg;

  localparam int D        = 6;                 // tree depth in levels
  localparam int K        = 3;                 // tuples per bucket
  localparam int A        = 8;                 // bytes per block value
  localparam int LW       = $clog2(D);         // level counter width
  localparam int NODES    = (2 ** D) - 1;      // buckets in the tree
  localparam int TUPLE_W  = 8 * A + 2 * D + 2;
  localparam int BUCKET_W = K * TUPLE_W;

  // One tuple, MSB first; tuple k of a bucket sits at [k*TUPLE_W +: TUPLE_W].
  typedef struct packed {
    logic             valid;
    logic             val_valid;
    logic [8*A-1:0]   val;
    logic [D-1:0]     b_number;
    logic             pos_valid;
    logic [D-2:0]     pos;
  } oram_tuple_t;

  typedef enum logic [1:0] {
    SRV_INIT  = 2'd0,
    SRV_IDLE  = 2'd1,
    SRV_READ  = 2'd2,
    SRV_WRITE = 2'd3
  } srv_state_e;

endpackage

// File: rtl/oram_path_server_if.sv
// Client <-> server handshake bundle: request, read-path stream, write-back stream.
interface oram_path_server_if;
  import oram_path_server_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [D-2:0]        req_leaf;
  logic                rd_valid;
  logic                rd_ready;
  logic [BUCKET_W-1:0] rd_bucket;
  logic [LW-1:0]       rd_level;
  logic                rd_last;
  logic                wr_valid;
  logic                wr_ready;
  logic [BUCKET_W-1:0] wr_bucket;
  logic                busy;
  logic                integrity_err;

  modport master (
    output req_valid, req_leaf, rd_ready, wr_valid, wr_bucket,
    input  req_ready, rd_valid, rd_bucket, rd_level, rd_last, wr_ready,
           busy, integrity_err
  );

  modport slave (
    input  req_valid, req_leaf, rd_ready, wr_valid, wr_bucket,
    output req_ready, rd_valid, rd_bucket, rd_level, rd_last, wr_ready,
           busy, integrity_err
  );
endinterface

// File: rtl/oram_path_server_bucket_store.sv
// Bucket storage for the whole tree: flop array, one combinational read
// port and one synchronous write port.
module oram_bucket_store
  import oram_path_server_pkg::*;
(
  input  logic                clk,
  input  logic                we,
  input  logic [D-1:0]        waddr,
  input  logic [BUCKET_W-1:0] wdata,
  input  logic [D-1:0]        raddr,
  output logic [BUCKET_W-1:0] rdata
);

  logic [BUCKET_W-1:0] mem [NODES];

  // Synchronous write; a write at edge W is visible to reads from W+1.
  // NOTE: the array has no reset; the server's INIT sweep zeroes every
  // bucket after each reset, so a reset network on this array would be wasted.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/oram_path_server.sv
// ORAM path server: holds every bucket of the tree, streams the D buckets of
// a requested path (root first) and absorbs D write-back buckets for it.
// Optional: define ORAM_SRV_INTEGRITY_EN to check write-back tuples against
// the latched leaf and raise a sticky integrity_err.
module oram_path_server
  import oram_path_server_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  oram_path_server_if.slave  bus
);

  srv_state_e          state_q, state_d;
  logic [D-2:0]        leaf_q, leaf_d;
  logic                rd_valid_q, rd_valid_d;
  logic [BUCKET_W-1:0] rd_bucket_q, rd_bucket_d;
  logic [LW-1:0]       rd_level_q, rd_level_d;
  logic                rd_last_q, rd_last_d;
  logic [LW-1:0]       wr_lvl_q, wr_lvl_d;
  logic [D-1:0]        init_cnt_q, init_cnt_d;

  logic                st_we;
  logic [D-1:0]        st_waddr;
  logic [BUCKET_W-1:0] st_wdata;
  logic [D-1:0]        st_raddr;
  logic [BUCKET_W-1:0] st_rdata;
  logic                wr_hs;

  // Node index on the path to leaf at level lvl: root = 1, each level
  // appends the next leaf bit (bit 0 chooses the child of the root).
  function automatic logic [D-1:0] node_idx(input logic [D-2:0] leaf,
                                            input logic [LW-1:0] lvl);
    logic [D-1:0] idx;
    idx = D'(1);
    for (int i = 0; i < D - 1; i++) begin
      if (LW'(i) < lvl) idx = {idx[D-2:0], leaf[i]};
    end
    return idx;
  endfunction

  oram_bucket_store u_store (
    .clk   (clk),
    .we    (st_we),
    .waddr (st_waddr),
    .wdata (st_wdata),
    .raddr (st_raddr),
    .rdata (st_rdata)
  );

  assign wr_hs = (state_q == SRV_WRITE) && bus.wr_valid;

  // Read address: the root while idle, otherwise the level after the one shown.
  always_comb begin
    st_raddr = '0;
    if (state_q == SRV_READ) begin
      st_raddr = node_idx(leaf_q, rd_level_q + LW'(1)) - D'(1);
    end
  end

  // Next-state, output-register and storage-write decode.
  // NOTE: every signal gets its default first so no path leaves it unassigned
  // (an unassigned path in always_comb would infer a latch).
  always_comb begin
    state_d     = state_q;
    leaf_d      = leaf_q;
    rd_valid_d  = rd_valid_q;
    rd_bucket_d = rd_bucket_q;
    rd_level_d  = rd_level_q;
    rd_last_d   = rd_last_q;
    wr_lvl_d    = wr_lvl_q;
    init_cnt_d  = init_cnt_q;
    st_we       = 1'b0;
    st_waddr    = '0;
    st_wdata    = '0;
    case (state_q)
      SRV_INIT: begin
        st_we      = 1'b1;
        st_waddr   = init_cnt_q;
        init_cnt_d = init_cnt_q + D'(1);
        if (init_cnt_q == D'(NODES - 1)) begin
          init_cnt_d = '0;
          state_d    = SRV_IDLE;
        end
      end
      SRV_IDLE: begin
        if (bus.req_valid) begin
          leaf_d      = bus.req_leaf;
          state_d     = SRV_READ;
          rd_valid_d  = 1'b1;
          rd_bucket_d = st_rdata;
          rd_level_d  = '0;
          rd_last_d   = (D == 1);
          wr_lvl_d    = '0;
        end
      end
      SRV_READ: begin
        if (rd_valid_q && bus.rd_ready) begin
          if (rd_last_q) begin
            state_d    = SRV_WRITE;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
          end else begin
            rd_level_d  = rd_level_q + LW'(1);
            rd_bucket_d = st_rdata;
            rd_last_d   = ((rd_level_q + LW'(1)) == LW'(D - 1));
          end
        end
      end
      SRV_WRITE: begin
        if (bus.wr_valid) begin
          st_we    = 1'b1;
          st_waddr = node_idx(leaf_q, wr_lvl_q) - D'(1);
          st_wdata = bus.wr_bucket;
          wr_lvl_d = wr_lvl_q + LW'(1);
          if (wr_lvl_q == LW'(D - 1)) begin
            wr_lvl_d = '0;
            state_d  = SRV_IDLE;
          end
        end
      end
      default: state_d = SRV_INIT;
    endcase
  end

  // State and output registers; reset aborts any access and restarts INIT.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SRV_INIT;
      leaf_q      <= '0;
      rd_valid_q  <= 1'b0;
      rd_bucket_q <= '0;
      rd_level_q  <= '0;
      rd_last_q   <= 1'b0;
      wr_lvl_q    <= '0;
      init_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      leaf_q      <= leaf_d;
      rd_valid_q  <= rd_valid_d;
      rd_bucket_q <= rd_bucket_d;
      rd_level_q  <= rd_level_d;
      rd_last_q   <= rd_last_d;
      wr_lvl_q    <= wr_lvl_d;
      init_cnt_q  <= init_cnt_d;
    end
  end

  assign bus.req_ready = (state_q == SRV_IDLE);
  assign bus.wr_ready  = (state_q == SRV_WRITE);
  assign bus.busy      = (state_q != SRV_IDLE);
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_bucket = rd_bucket_q;
  assign bus.rd_level  = rd_level_q;
  assign bus.rd_last   = rd_last_q;

`ifdef ORAM_SRV_INTEGRITY_EN
  logic err_q, err_d;

  // Flag any valid, positioned tuple whose low L pos bits leave the path.
  always_comb begin
    oram_tuple_t t;
    err_d = err_q;
    t     = '0;
    if (wr_hs) begin
      for (int k = 0; k < K; k++) begin
        t = bus.wr_bucket[k*TUPLE_W +: TUPLE_W];
        for (int i = 0; i < D - 1; i++) begin
          if (t.valid && t.pos_valid && (LW'(i) < wr_lvl_q) &&
              (t.pos[i] != leaf_q[i])) begin
            err_d = 1'b1;
          end
        end
      end
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign bus.integrity_err = err_q;
`else
  logic unused_wr_hs;
  assign unused_wr_hs      = wr_hs;
  assign bus.integrity_err = 1'b0;
`endif

endmodule

// File: tb/tb_oram_path_server.sv
// Self-checking bench for oram_path_server: directed plan items plus random
// accesses against a leaf/level array model of the tree.
module tb_oram_path_server;
  import oram_path_server_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  oram_path_server_if bus();

  oram_path_server dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [BUCKET_W-1:0] model [1:NODES];
  bit                  model_err;
  logic [BUCKET_W-1:0] wb_buf [D];

  task automatic check(input string tag, input logic [BUCKET_W-1:0] got,
                       input logic [BUCKET_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int node_of(input int leaf, input int lvl);
    int n = 1;
    for (int i = 0; i < lvl; i++) n = 2 * n + ((leaf >> i) & 1);
    return n;
  endfunction

  function automatic logic [TUPLE_W-1:0] make_tuple(
      input bit v, input bit vv, input logic [8*A-1:0] val,
      input logic [D-1:0] b, input bit pv, input logic [D-2:0] pos);
    return {v, vv, val, b, pv, pos};
  endfunction

  // True if some valid, positioned tuple is off the path at this level.
  function automatic bit bucket_off_path(input logic [BUCKET_W-1:0] bk,
                                         input int leaf, input int lvl);
    logic [TUPLE_W-1:0] t;
    int mask = (1 << lvl) - 1;
    for (int k = 0; k < K; k++) begin
      t = TUPLE_W'(bk >> (k * TUPLE_W));
      if (t[TUPLE_W-1] && t[D-1] && ((int'(t[D-2:0]) & mask) != (leaf & mask)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [BUCKET_W-1:0] rand_bucket();
    logic [BUCKET_W-1:0] bk = '0;
    logic [TUPLE_W-1:0]  t;
    for (int k = 0; k < K; k++) begin
      t = make_tuple(1'($urandom), 1'($urandom), {$urandom, $urandom},
                     D'($urandom), 1'($urandom), (D-1)'($urandom));
      bk = bk | (BUCKET_W'(t) << (k * TUPLE_W));
    end
    return bk;
  endfunction

  task automatic fill_identity(input int leaf);
    for (int l = 0; l < D; l++) wb_buf[l] = model[node_of(leaf, l)];
  endtask

  task automatic clear_model();
    for (int n = 1; n <= NODES; n++) model[n] = '0;
    model_err = 1'b0;
  endtask

  task automatic count_init();
    int n = 0;
    while (!bus.req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("init_cycles", BUCKET_W'(n), BUCKET_W'(NODES));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, BUCKET_W'(bus.req_ready), '0);
    check({tag, "_rd_valid"},  BUCKET_W'(bus.rd_valid), '0);
    check({tag, "_rd_bucket"}, bus.rd_bucket, '0);
    check({tag, "_rd_level"},  BUCKET_W'(bus.rd_level), '0);
    check({tag, "_rd_last"},   BUCKET_W'(bus.rd_last), '0);
    check({tag, "_wr_ready"},  BUCKET_W'(bus.wr_ready), '0);
    check({tag, "_busy"},      BUCKET_W'(bus.busy), BUCKET_W'(1));
    check({tag, "_err"},       BUCKET_W'(bus.integrity_err), '0);
  endtask

  // One full access: request, D reads (optional stall), D writes of wb_buf.
  // misuse drives wr_valid while reading and req_valid while writing.
  task automatic run_access(input int leaf, input int stall_lvl,
                            input int stall_n, input bit misuse, input bit gaps);
    int n = 0;
    logic [BUCKET_W-1:0] exp;
    while (!bus.req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_idle", BUCKET_W'(bus.req_ready), BUCKET_W'(1));
    if (!bus.req_ready) return;
    check("busy_idle", BUCKET_W'(bus.busy), '0);
    bus.req_valid = 1'b1;
    bus.req_leaf  = (D-1)'(leaf);
    bus.rd_ready  = 1'b1;
    if (misuse) begin
      bus.wr_valid  = 1'b1;
      bus.wr_bucket = rand_bucket();
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int l = 0; l < D; l++) begin
      exp = model[node_of(leaf, l)];
      if (l == stall_lvl) begin
        bus.rd_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          check("stall_valid",  BUCKET_W'(bus.rd_valid), BUCKET_W'(1));
          check("stall_level",  BUCKET_W'(bus.rd_level), BUCKET_W'(l));
          check("stall_bucket", bus.rd_bucket, exp);
        end
        bus.rd_ready = 1'b1;
      end
      check("rd_valid",  BUCKET_W'(bus.rd_valid), BUCKET_W'(1));
      check("rd_level",  BUCKET_W'(bus.rd_level), BUCKET_W'(l));
      check("rd_last",   BUCKET_W'(bus.rd_last), BUCKET_W'(l == D - 1));
      check("rd_bucket", bus.rd_bucket, exp);
      check("wr_ready_rd", BUCKET_W'(bus.wr_ready), '0);
      @(negedge clk);
    end
    bus.rd_ready = 1'b0;
    if (misuse) begin
      bus.wr_valid  = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_leaf  = (D-1)'(~leaf);
    end
    check("wr_ready", BUCKET_W'(bus.wr_ready), BUCKET_W'(1));
    check("rd_valid_wr", BUCKET_W'(bus.rd_valid), '0);
    for (int l = 0; l < D; l++) begin
      if (gaps && ($urandom % 3 == 0)) begin
        bus.wr_valid = 1'b0;
        @(negedge clk);
        check("wr_ready_gap", BUCKET_W'(bus.wr_ready), BUCKET_W'(1));
      end
      bus.wr_valid  = 1'b1;
      bus.wr_bucket = wb_buf[l];
      @(negedge clk);
      model[node_of(leaf, l)] = wb_buf[l];
`ifdef ORAM_SRV_INTEGRITY_EN
      if (bucket_off_path(wb_buf[l], leaf, l)) model_err = 1'b1;
`endif
      check("integrity_err", BUCKET_W'(bus.integrity_err), BUCKET_W'(model_err));
    end
    bus.wr_valid  = 1'b0;
    bus.req_valid = 1'b0;
    check("req_ready_after", BUCKET_W'(bus.req_ready), BUCKET_W'(1));
  endtask

  initial begin
    int leaf;
    int sl;
    bus.req_valid = 1'b0;
    bus.req_leaf  = '0;
    bus.rd_ready  = 1'b0;
    bus.wr_valid  = 1'b0;
    bus.wr_bucket = '0;
    clear_model();

    // Reset state and INIT sweep length.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    count_init();

    // All-zero tree on leaf 0.
    fill_identity(0);
    run_access(0, -1, 0, 1'b0, 1'b0);

    // Plant a tuple at level 2 of leaf 5'b00101, then read it from siblings.
    fill_identity(5);
    wb_buf[2] = BUCKET_W'(make_tuple(1'b1, 1'b1, 64'hDEADBEEF_00000001,
                                     D'(9), 1'b1, 5'b00101));
    run_access(5, -1, 0, 1'b0, 1'b0);
    fill_identity(21);
    run_access(21, -1, 0, 1'b0, 1'b0);
    check("node6_tuple", model[node_of(21, 2)],
          BUCKET_W'(make_tuple(1'b1, 1'b1, 64'hDEADBEEF_00000001,
                               D'(9), 1'b1, 5'b00101)));
    fill_identity(6);
    run_access(6, -1, 0, 1'b0, 1'b0);

    // Backpressure at level 3, then protocol misuse with write gaps.
    fill_identity(21);
    run_access(21, 3, 3, 1'b0, 1'b0);
    fill_identity(5);
    run_access(5, -1, 0, 1'b1, 1'b1);
    fill_identity(21);
    run_access(21, 1, 2, 1'b0, 1'b0);

    // Off-path tuple at level 2 of leaf 5'b00101.
    fill_identity(5);
    wb_buf[2] = BUCKET_W'(make_tuple(1'b1, 1'b0, 64'h0, D'(3), 1'b1, 5'b00000));
    run_access(5, -1, 0, 1'b0, 1'b0);

    // Random accesses.
    for (int i = 0; i < 30; i++) begin
      leaf = int'($urandom_range(0, (1 << (D - 1)) - 1));
      for (int l = 0; l < D; l++)
        wb_buf[l] = ($urandom % 2 == 0) ? rand_bucket() : model[node_of(leaf, l)];
      sl = ($urandom % 2 == 0) ? int'($urandom_range(0, D - 1)) : -1;
      run_access(leaf, sl, int'($urandom_range(1, 3)), 1'($urandom), 1'($urandom));
    end

    // Known tuple on leaf 5'b10101, then reset while level 2 is presented.
    fill_identity(21);
    wb_buf[2] = BUCKET_W'(make_tuple(1'b1, 1'b1, 64'hDEADBEEF_00000001,
                                     D'(9), 1'b1, 5'b10101));
    run_access(21, -1, 0, 1'b0, 1'b0);
    bus.req_valid = 1'b1;
    bus.req_leaf  = 5'b10101;
    bus.rd_ready  = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_level", BUCKET_W'(bus.rd_level), BUCKET_W'(2));
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    bus.rd_ready = 1'b0;
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    count_init();
    fill_identity(21);
    run_access(21, -1, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
